program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
Upstream instruction feeder for the cpu block. Holds a small program RAM and replays it into the cpu's instruction interface, one instruction at a time. For each instruction it presents the word on `cpu_in`, pulses `cpu_load` and then `cpu_s`, and waits for the cpu's `w` handshake before moving on. It replaces hand-driven load/s sequencing, and adds done/error status plus a watchdog on the cpu handshake.

Parameters:
AW, 4, program address width; RAM depth = 2**AW words.
IW, 16, instruction width; must match cpu `in`.
TIMEOUT, 64, maximum cycles spent in either wait state before error.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low; 0 at a rising clk edge resets.
prog_we  input  1  program RAM write enable; ignored while busy=1.
prog_addr  input  AW  program RAM write address.
prog_wdata  input  IW  program RAM write data.
start  input  1  begin run; sampled only in IDLE, DONE or ERR.
len  input  AW+1  number of instructions to run, 0..2**AW; latched when start is accepted.
cpu_w  input  1  cpu waiting flag; 1 = cpu idle and ready.
cpu_in  output  IW  instruction word to cpu; registered.
cpu_load  output  1  one-cycle load strobe to cpu.
cpu_s  output  1  one-cycle start strobe to cpu.
pc  output  AW  index of the current instruction.
busy  output  1  1 in any state except IDLE, DONE, ERR.
done  output  1  1 in DONE.
err  output  1  1 in ERR (watchdog expired).

Behaviour:
- Reset (reset=0 at clk edge): state←IDLE, cpu_in←0, pc←0, len_q←0, wdog←0. Outputs cpu_load=cpu_s=busy=done=err=0. RAM contents are NOT cleared. Reset has priority over every other input, including mid-run.
- RAM: synchronous write on prog_we when not busy. Synchronous read, one-cycle latency.
- `cpu_load`, `cpu_s`, `busy`, `done`, `err` are Moore-decoded from state. `cpu_in` holds its value until the next FETCH.
- States and transitions:
  - IDLE/DONE/ERR + start=1: if len=0, go to DONE. Otherwise go to FETCH with pc←0 and len_q←len.
  - IDLE/DONE/ERR + start=0: hold current state.
  - FETCH: cpu_in←ram[pc]; go to LOAD.
  - LOAD: cpu_load=1; go to START.
  - START: cpu_s=1; wdog←0; go to WAIT_LOW.
  - WAIT_LOW: if cpu_w=0, go to WAIT_HIGH with wdog←0. Otherwise wdog++.
  - WAIT_HIGH: if cpu_w=1, go to NEXT. Otherwise wdog++.
  - NEXT: if pc==len_q-1, go to DONE (pc holds). Otherwise pc++ and go to FETCH.
  - Watchdog: in WAIT_LOW or WAIT_HIGH with wdog==TIMEOUT-1 and the exit condition false, go to ERR. pc freezes at the failing instruction.
- Timing: each instruction costs 5 sequencer cycles plus the cpu execution time. The first cpu_load asserts 2 cycles after start is accepted. cpu_s asserts exactly 1 cycle after each cpu_load.
- Boundaries:
  - len=2**AW runs every word; pc never wraps.
  - start while busy is ignored.
  - prog_we and start in the same cycle from IDLE: the write completes, and the run starts with FETCH on the following cycle, so it sees the new word.
  - wdog width is clog2(TIMEOUT)+1 bits and saturates; it never wraps.

Decomposition:
- Shared header: state encodings (IDLE, FETCH, LOAD, START, WAIT_LOW, WAIT_HIGH, NEXT, DONE, ERR as localparams) and the default AW/IW/TIMEOUT constants. The cpu bench includes the same header.
- One sub-module, `prog_ram`: AW×IW, single write port, one synchronous read port, no reset.

Test Plan:
- Reset hold of 2 cycles -> cpu_in=0, cpu_load=cpu_s=busy=done=err=0, pc=0; RAM word written before reset still reads back after it.
- Load 16'hD146, 16'hD202, 16'hA145 at addresses 0..2, len=3, start, real cpu attached -> exactly three cpu_load pulses carrying those words in order, each followed next cycle by one cpu_s pulse; done=1 after the third w rise; cpu R1=16'd70 and R2=16'd2 after the MOVs.
- len=0, start -> done=1 on the next cycle; no cpu_load or cpu_s pulse; pc=0.
- cpu_w stub stuck at 1 after cpu_s -> err=1 exactly TIMEOUT cycles after START; busy=0, pc=0; cpu_load and cpu_s stay 0; a new start restarts from pc 0.
- reset=0 for one cycle while in WAIT_HIGH of instruction 1 -> IDLE next cycle with all outputs 0; re-start with len=3 replays from word 0 with RAM intact.
- During a run, drive prog_we to address 1 with 16'hFFFF and pulse start -> RAM word 1 unchanged (reads 16'hD202 next run); run proceeds to completion unaffected.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_sequencer_pkg
//  Description : Shared definitions for the program sequencer. Holds the
//                sequencer state encodings and the default address width,
//                instruction width and watchdog limit. The cpu bench includes
//                the same header so both sides agree on the encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package program_sequencer_pkg;

    localparam int c_AW_DEFAULT      = 4;
    localparam int c_IW_DEFAULT      = 16;
    localparam int c_TIMEOUT_DEFAULT = 64;

    localparam int c_STATE_W = 4;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE      = 4'd0;
    localparam state_t c_ST_FETCH     = 4'd1;
    localparam state_t c_ST_LOAD      = 4'd2;
    localparam state_t c_ST_START     = 4'd3;
    localparam state_t c_ST_WAIT_LOW  = 4'd4;
    localparam state_t c_ST_WAIT_HIGH = 4'd5;
    localparam state_t c_ST_NEXT      = 4'd6;
    localparam state_t c_ST_DONE      = 4'd7;
    localparam state_t c_ST_ERR       = 4'd8;

endpackage : program_sequencer_pkg
`default_nettype wire

// File: rtl/prog_ram.sv
`default_nettype none
// ============================================================================
//  Module      : prog_ram
//  Description : 2**AW x IW program store. One synchronous write port and one
//                synchronous read port (one-cycle latency). No reset: contents
//                survive a sequencer reset.
//  Ports       : clk      - rising-edge clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_raddr  - read address, captured every cycle
//                o_rdata  - registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module prog_ram
    import program_sequencer_pkg::*;
#(
    parameter int AW = c_AW_DEFAULT,
    parameter int IW = c_IW_DEFAULT
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);

    logic [IW-1:0] r_mem_q [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
        // Write-first on an address collision: a run started in the same
        // cycle as a program write must fetch the freshly written word.
        if (i_we && (i_waddr == i_raddr)) begin
            o_rdata <= i_wdata;
        end else begin
            o_rdata <= r_mem_q[i_raddr];
        end
    end

endmodule : prog_ram
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : program_sequencer
//  Description : Replays a small program RAM into the cpu instruction
//                interface. Per instruction: fetch word, pulse cpu_load, pulse
//                cpu_s, then wait for cpu_w to fall and rise again. A watchdog
//                bounds each wait; expiry parks the sequencer in ERR.
//  Ports       : clk        - rising-edge clock
//                reset      - synchronous, active-low
//                prog_we    - program write enable (ignored while busy)
//                prog_addr  - program write address
//                prog_wdata - program write data
//                start      - begin a run (honoured in IDLE/DONE/ERR only)
//                len        - instruction count 0..2**AW, latched on start
//                cpu_w      - cpu idle/ready flag
//                cpu_in     - registered instruction word to cpu
//                cpu_load   - one-cycle load strobe
//                cpu_s      - one-cycle start strobe
//                pc         - index of current instruction
//                busy/done/err - status decoded from state
//  Revision    : 1.0  initial release
// ============================================================================
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int AW      = c_AW_DEFAULT,
    parameter int IW      = c_IW_DEFAULT,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_wdata,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          cpu_w,
    output logic [IW-1:0] cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int                  c_WDOG_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_MAX  = {c_WDOG_W{1'b1}};

    state_t              r_state_q,  w_state_d;
    logic [AW-1:0]       r_pc_q,     w_pc_d;
    logic [AW:0]         r_len_q,    w_len_d;
    logic [c_WDOG_W-1:0] r_wdog_q,   w_wdog_d;
    logic [c_WDOG_W-1:0] w_wdog_inc;
    logic [IW-1:0]       r_cpu_in_q, w_cpu_in_d;
    logic [IW-1:0]       w_ram_rdata;
    logic                w_busy;

    assign w_busy   = (r_state_q != c_ST_IDLE) && (r_state_q != c_ST_DONE)
                   && (r_state_q != c_ST_ERR);
    assign busy     = w_busy;
    assign done     = (r_state_q == c_ST_DONE);
    assign err      = (r_state_q == c_ST_ERR);
    assign cpu_load = (r_state_q == c_ST_LOAD);
    assign cpu_s    = (r_state_q == c_ST_START);
    assign cpu_in   = r_cpu_in_q;
    assign pc       = r_pc_q;

    // The read address follows the next pc so the word for FETCH is already
    // registered when FETCH is entered.
    prog_ram #(
        .AW (AW),
        .IW (IW)
    ) u_prog_ram (
        .clk     (clk),
        .i_we    (prog_we & ~w_busy),
        .i_waddr (prog_addr),
        .i_wdata (prog_wdata),
        .i_raddr (w_pc_d),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_pc_d     = r_pc_q;
        w_len_d    = r_len_q;
        w_wdog_d   = r_wdog_q;
        w_cpu_in_d = r_cpu_in_q;
        w_wdog_inc = (r_wdog_q == c_WDOG_MAX) ? r_wdog_q
                                              : r_wdog_q + c_WDOG_W'(1);
        case (r_state_q)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                if (start) begin
                    w_pc_d = '0;
                    if (len == '0) begin
                        w_state_d = c_ST_DONE;
                    end else begin
                        w_state_d = c_ST_FETCH;
                        w_len_d   = len;
                    end
                end
            end
            c_ST_FETCH: begin
                w_cpu_in_d = w_ram_rdata;
                w_state_d  = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                w_state_d = c_ST_START;
            end
            c_ST_START: begin
                w_wdog_d  = '0;
                w_state_d = c_ST_WAIT_LOW;
            end
            c_ST_WAIT_LOW: begin
                if (!cpu_w) begin
                    w_wdog_d  = '0;
                    w_state_d = c_ST_WAIT_HIGH;
                end else if (r_wdog_q == c_WDOG_LAST) begin
                    w_state_d = c_ST_ERR;
                end else begin
                    w_wdog_d = w_wdog_inc;
                end
            end
            c_ST_WAIT_HIGH: begin
                if (cpu_w) begin
                    w_state_d = c_ST_NEXT;
                end else if (r_wdog_q == c_WDOG_LAST) begin
                    w_state_d = c_ST_ERR;
                end else begin
                    w_wdog_d = w_wdog_inc;
                end
            end
            c_ST_NEXT: begin
                // Compared in AW+1 bits so len = 2**AW ends at pc = 2**AW-1
                // without pc ever wrapping.
                if ({1'b0, r_pc_q} == (r_len_q - (AW+1)'(1))) begin
                    w_state_d = c_ST_DONE;
                end else begin
                    w_pc_d    = r_pc_q + AW'(1);
                    w_state_d = c_ST_FETCH;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q  <= c_ST_IDLE;
            r_pc_q     <= '0;
            r_len_q    <= '0;
            r_wdog_q   <= '0;
            r_cpu_in_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_len_q    <= w_len_d;
            r_wdog_q   <= w_wdog_d;
            r_cpu_in_q <= w_cpu_in_d;
        end
    end

endmodule : program_sequencer
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_sequencer
//  Description : Scoreboard bench for program_sequencer. Stimulus pushes the
//                words the cpu must receive; a monitor pops one per cpu_load
//                and checks that cpu_s follows one cycle later. A behavioural
//                cpu stub drives cpu_w (normal handshake or stuck high).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_program_sequencer;

    localparam int AW      = 4;
    localparam int IW      = 16;
    localparam int TIMEOUT = 64;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          prog_we    = 1'b0;
    logic [AW-1:0] prog_addr  = '0;
    logic [IW-1:0] prog_wdata = '0;
    logic          start      = 1'b0;
    logic [AW:0]   len        = '0;
    logic          cpu_w      = 1'b1;
    logic [IW-1:0] cpu_in;
    logic          cpu_load;
    logic          cpu_s;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;

    int            n_checks   = 0;
    int            n_fail     = 0;
    logic [IW-1:0] exp_q[$];
    bit            stub_stuck = 1'b0;
    int            stub_cnt   = 0;
    int            exec_cycles = 3;
    bit            pend_s     = 1'b0;

    always #5 clk = ~clk;

    program_sequencer #(
        .AW      (AW),
        .IW      (IW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .len        (len),
        .cpu_w      (cpu_w),
        .cpu_in     (cpu_in),
        .cpu_load   (cpu_load),
        .cpu_s      (cpu_s),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // cpu stub: cpu_w drops the edge after cpu_s, stays low exec_cycles cycles.
    always @(posedge clk) begin
        if (!reset) begin
            cpu_w    <= 1'b1;
            stub_cnt <= 0;
        end else if (stub_stuck) begin
            cpu_w <= 1'b1;
        end else if (cpu_s) begin
            cpu_w    <= 1'b0;
            stub_cnt <= exec_cycles;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else if (stub_cnt == 1) begin
            stub_cnt <= 0;
            cpu_w    <= 1'b1;
        end
    end

    // Monitor: one queue pop per cpu_load, cpu_s exactly one cycle later.
    always @(negedge clk) begin
        if (reset) begin
            if (pend_s || cpu_s) check("cpu_s_after_load", {31'd0, cpu_s}, {31'd0, pend_s});
            if (cpu_load) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cpu_load_unexpected: got word %h, required no load", cpu_in);
                end else begin
                    check("cpu_in_word", {16'd0, cpu_in}, {16'd0, exp_q.pop_front()});
                end
            end
            pend_s = cpu_load;
        end else begin
            pend_s = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic start_run(input logic [AW:0] l);
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n = 0;
        while (!done && !err && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_cpu_s(input string name, input logic [AW-1:0] want_pc);
        int n = 0;
        while (!(cpu_s && pc == want_pc) && n < 100) begin
            tick();
            n++;
        end
        check(name, {31'd0, cpu_s}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cpu_in"},   {16'd0, cpu_in}, 32'd0);
        check({tag, "_cpu_load"}, {31'd0, cpu_load}, 32'd0);
        check({tag, "_cpu_s"},    {31'd0, cpu_s}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy}, 32'd0);
        check({tag, "_done"},     {31'd0, done}, 32'd0);
        check({tag, "_err"},      {31'd0, err}, 32'd0);
        check({tag, "_pc"},       {28'd0, pc}, 32'd0);
    endtask

    initial begin
        int n;
        logic [IW-1:0] w;

        // Establish a known state, store a word, then reset again over it.
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        write_word(4'd0, 16'hBEEF);
        reset = 1'b0;
        tick(); tick();
        check_idle_outputs("reset");
        reset = 1'b1;
        tick();

        // RAM survives reset.
        exp_q.push_back(16'hBEEF);
        start_run(5'd1);
        wait_done("ram_after_reset_done", 50);

        // Basic three-instruction program.
        write_word(4'd0, 16'hD146);
        write_word(4'd1, 16'hD202);
        write_word(4'd2, 16'hA145);
        exp_q.push_back(16'hD146);
        exp_q.push_back(16'hD202);
        exp_q.push_back(16'hA145);
        start_run(5'd3);
        check("first_cycle_busy", {31'd0, busy}, 32'd1);
        wait_done("prog3_done", 100);
        check("prog3_pc", {28'd0, pc}, 32'd2);
        check("prog3_busy", {31'd0, busy}, 32'd0);

        // len = 0 goes straight to DONE.
        start_run(5'd0);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_pc", {28'd0, pc}, 32'd0);
        check("len0_busy", {31'd0, busy}, 32'd0);
        tick(); tick();

        // Watchdog: cpu never drops cpu_w.
        stub_stuck = 1'b1;
        exp_q.push_back(16'hD146);
        start_run(5'd3);
        wait_cpu_s("wdog_cpu_s_seen", 4'd0);
        n = 0;
        tick();
        while (!err && n < 200) begin
            n++;
            tick();
        end
        check("wdog_cycles", n, TIMEOUT);
        check("wdog_err", {31'd0, err}, 32'd1);
        check("wdog_busy", {31'd0, busy}, 32'd0);
        check("wdog_pc", {28'd0, pc}, 32'd0);
        repeat (5) tick();
        check("wdog_err_held", {31'd0, err}, 32'd1);
        stub_stuck = 1'b0;
        tick();
        exp_q.push_back(16'hD146);
        exp_q.push_back(16'hD202);
        exp_q.push_back(16'hA145);
        start_run(5'd3);
        wait_done("restart_after_err_done", 100);

        // Reset while waiting on instruction 1.
        exp_q.push_back(16'hD146);
        exp_q.push_back(16'hD202);
        exp_q.push_back(16'hA145);
        start_run(5'd3);
        wait_cpu_s("reset_test_cpu_s_pc1", 4'd1);
        tick(); tick();
        check("reset_test_wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        check_idle_outputs("midrun_reset");

        // Write and start in the same cycle from IDLE.
        prog_we    = 1'b1;
        prog_addr  = 4'd0;
        prog_wdata = 16'h5A5A;
        len        = 5'd1;
        start      = 1'b1;
        exp_q.push_back(16'h5A5A);
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        wait_done("same_cycle_write_done", 50);

        write_word(4'd0, 16'hD146);
        exp_q.push_back(16'hD146);
        exp_q.push_back(16'hD202);
        exp_q.push_back(16'hA145);
        start_run(5'd3);
        wait_done("replay_after_reset_done", 100);

        // Write and start attempts while busy are ignored.
        exp_q.push_back(16'hD146);
        exp_q.push_back(16'hD202);
        exp_q.push_back(16'hA145);
        start_run(5'd3);
        tick(); tick(); tick();
        prog_we    = 1'b1;
        prog_addr  = 4'd1;
        prog_wdata = 16'hFFFF;
        len        = 5'd1;
        start      = 1'b1;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        wait_done("busy_write_run_done", 100);
        check("busy_write_run_pc", {28'd0, pc}, 32'd2);
        exp_q.push_back(16'hD146);
        exp_q.push_back(16'hD202);
        exp_q.push_back(16'hA145);
        start_run(5'd3);
        wait_done("busy_write_rerun_done", 100);

        // Full depth run.
        for (int i = 0; i < 16; i++) begin
            w = 16'h8000 + 16'(i * 16'h0111);
            write_word(4'(i), w);
            exp_q.push_back(w);
        end
        start_run(5'd16);
        wait_done("full_depth_done", 400);
        check("full_depth_pc", {28'd0, pc}, 32'd15);
        check("full_depth_err", {31'd0, err}, 32'd0);

        tick(); tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule : tb_program_sequencer
`default_nettype wire
